// File: rtl/ws_pe_mac_v2.sv
// ws_pe_mac_v2: weight-stationary processing element with a bank of stationary weights.
//
// A valid/ready weight stream fills a NUM_W-entry bank, wrapping so later weights overwrite
// earlier ones. In COMPUTE, each accepted input is multiplied by bank[w_sel], signed or unsigned
// per the mode latched on the first weight of a load, and accumulated. Every accepted input is
// forwarded to the neighbouring PE one cycle later. The final input of a pass moves the FSM to
// DRAIN, where the result is offered over a valid/ready handshake.
//
// Build option:
//   PE_SAT_EN  defined   -> accumulator saturates to the mode's min/max, w_ovf is sticky
//              undefined -> accumulator wraps modulo 2^ACC_WIDTH, w_ovf is tied to 0
//
// Ports:
//   w_clk, w_rst              clock, synchronous active-high reset
//   w_signed                  operand mode, latched on the first weight accepted from IDLE
//   w_wt_valid/ready/data/last weight stream
//   w_sel                     bank index used for compute (out-of-range selects a weight of 0)
//   w_in_valid/ready/data/last input stream
//   w_fwd_valid/data          registered copy of each accepted input (systolic output)
//   w_out_valid/ready/data    result handshake; w_out_data is the accumulator
//   w_reuse                   at result handshake: 1 = keep weights, return to COMPUTE
//   w_count                   saturating count of inputs accepted in the current pass
//   w_ovf                     sticky overflow flag
//   w_state                   FSM state (IDLE=0, LOAD=1, COMPUTE=2, DRAIN=3)
module ws_pe_mac_v2 #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned NUM_W     = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                     w_clk,
    input  logic                     w_rst,
    input  logic                     w_signed,
    input  logic                     w_wt_valid,
    output logic                     w_wt_ready,
    input  logic [WIDTH-1:0]         w_wt_data,
    input  logic                     w_wt_last,
    input  logic [$clog2(NUM_W)-1:0] w_sel,
    input  logic                     w_in_valid,
    output logic                     w_in_ready,
    input  logic [WIDTH-1:0]         w_in_data,
    input  logic                     w_in_last,
    output logic                     w_fwd_valid,
    output logic [WIDTH-1:0]         w_fwd_data,
    output logic                     w_out_valid,
    input  logic                     w_out_ready,
    output logic [ACC_WIDTH-1:0]     w_out_data,
    input  logic                     w_reuse,
    output logic [CNT_WIDTH-1:0]     w_count,
    output logic                     w_ovf,
    output logic [1:0]               w_state
);

    localparam int unsigned SEL_W = $clog2(NUM_W);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoad    = 2'd1,
        StCompute = 2'd2,
        StDrain   = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     bank_q [NUM_W];
    logic [SEL_W-1:0]     wptr_q;
    logic                 signed_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 fwd_valid_q;
    logic [WIDTH-1:0]     fwd_data_q;

    logic wt_fire, in_fire, out_fire;

    // Handshake readies decode the state register only.
    assign w_wt_ready  = (state_q == StIdle) || (state_q == StLoad);
    assign w_in_ready  = (state_q == StCompute);
    assign w_out_valid = (state_q == StDrain);

    assign wt_fire  = w_wt_valid & w_wt_ready;
    assign in_fire  = w_in_valid & w_in_ready;
    assign out_fire = w_out_valid & w_out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (wt_fire) state_d = w_wt_last ? StCompute : StLoad;
            StLoad:    if (wt_fire && w_wt_last) state_d = StCompute;
            StCompute: if (in_fire && w_in_last) state_d = StDrain;
            StDrain:   if (out_fire) state_d = w_reuse ? StCompute : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Weight select; a non-power-of-two bank needs a guard for unused indices.
    logic [WIDTH-1:0] wt_cur;
    if (NUM_W == (1 << SEL_W)) begin : g_sel_full
        assign wt_cur = bank_q[w_sel];
    end else begin : g_sel_guard
        assign wt_cur = (32'(w_sel) < NUM_W) ? bank_q[w_sel] : '0;
    end

    // Extending both operands to 2*WIDTH per mode makes one multiplier serve both modes:
    // the low 2*WIDTH bits of the product are the exact signed or unsigned result.
    logic [2*WIDTH-1:0]     op_w, op_x, prod;
    logic signed [2*WIDTH:0] prod_sx;
    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH-1:0]   acc_sum;

    always_comb begin
        op_w     = {{WIDTH{signed_q & wt_cur[WIDTH-1]}}, wt_cur};
        op_x     = {{WIDTH{signed_q & w_in_data[WIDTH-1]}}, w_in_data};
        prod     = op_w * op_x;
        prod_sx  = {signed_q & prod[2*WIDTH-1], prod};
        prod_ext = ACC_WIDTH'(prod_sx);
    end

`ifdef PE_SAT_EN
    logic [ACC_WIDTH:0] sum_x;
    logic               ovf_now;
    logic               ovf_q;

    always_comb begin
        sum_x   = {signed_q & acc_q[ACC_WIDTH-1], acc_q}
                + {signed_q & prod_ext[ACC_WIDTH-1], prod_ext};
        // Signed: top two bits disagree. Unsigned: carry out.
        ovf_now = signed_q ? (sum_x[ACC_WIDTH] != sum_x[ACC_WIDTH-1]) : sum_x[ACC_WIDTH];
        acc_sum = sum_x[ACC_WIDTH-1:0];
        if (ovf_now) begin
            if (!signed_q) begin
                acc_sum = '1;
            end else if (sum_x[ACC_WIDTH]) begin
                acc_sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                acc_sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            ovf_q <= 1'b0;
        end else if (out_fire) begin
            ovf_q <= 1'b0;
        end else if (in_fire && ovf_now) begin
            ovf_q <= 1'b1;
        end
    end

    assign w_ovf = ovf_q;
`else
    assign acc_sum = acc_q + prod_ext;
    assign w_ovf   = 1'b0;
`endif

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q     <= StIdle;
            for (int i = 0; i < int'(NUM_W); i++) bank_q[i] <= '0;
            wptr_q      <= '0;
            signed_q    <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            fwd_valid_q <= in_fire;

            if (wt_fire) begin
                bank_q[wptr_q] <= w_wt_data;
                if (state_q == StIdle) signed_q <= w_signed;
                if (w_wt_last) begin
                    wptr_q <= '0;
                end else if (wptr_q == SEL_W'(NUM_W - 1)) begin
                    wptr_q <= '0;
                end else begin
                    wptr_q <= wptr_q + 1'b1;
                end
            end

            if (in_fire) begin
                acc_q      <= acc_sum;
                fwd_data_q <= w_in_data;
                if (count_q != '1) count_q <= count_q + 1'b1;
            end

            if (out_fire) begin
                acc_q   <= '0;
                count_q <= '0;
            end
        end
    end

    assign w_fwd_valid = fwd_valid_q;
    assign w_fwd_data  = fwd_data_q;
    assign w_out_data  = acc_q;
    assign w_count     = count_q;
    assign w_state     = state_q;

endmodule

// File: tb/tb_ws_pe_mac_v2.sv
// Directed bench for ws_pe_mac_v2 (WIDTH=16, ACC_WIDTH=32, NUM_W=4, CNT_WIDTH=16).
module tb_ws_pe_mac_v2;

    localparam int WIDTH = 16;
    localparam int ACC   = 32;
    localparam int NUM_W = 4;
    localparam int CNT   = 16;

    logic             clk;
    logic             rst;
    logic             sgn;
    logic             wt_valid, wt_ready, wt_last;
    logic [WIDTH-1:0] wt_data;
    logic [1:0]       sel;
    logic             in_valid, in_ready, in_last;
    logic [WIDTH-1:0] in_data;
    logic             fwd_valid;
    logic [WIDTH-1:0] fwd_data;
    logic             out_valid, out_ready;
    logic [ACC-1:0]   out_data;
    logic             reuse;
    logic [CNT-1:0]   count;
    logic             ovf;
    logic [1:0]       state;

    int checks   = 0;
    int failures = 0;

    ws_pe_mac_v2 #(
        .WIDTH    (WIDTH),
        .ACC_WIDTH(ACC),
        .NUM_W    (NUM_W),
        .CNT_WIDTH(CNT)
    ) dut (
        .w_clk      (clk),
        .w_rst      (rst),
        .w_signed   (sgn),
        .w_wt_valid (wt_valid),
        .w_wt_ready (wt_ready),
        .w_wt_data  (wt_data),
        .w_wt_last  (wt_last),
        .w_sel      (sel),
        .w_in_valid (in_valid),
        .w_in_ready (in_ready),
        .w_in_data  (in_data),
        .w_in_last  (in_last),
        .w_fwd_valid(fwd_valid),
        .w_fwd_data (fwd_data),
        .w_out_valid(out_valid),
        .w_out_ready(out_ready),
        .w_out_data (out_data),
        .w_reuse    (reuse),
        .w_count    (count),
        .w_ovf      (ovf),
        .w_state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers are entered and left 1 time unit after a rising edge.
    task automatic send_wt(input logic [WIDTH-1:0] d, input logic last);
        int n = 0;
        wt_data = d; wt_last = last; wt_valid = 1'b1;
        while (wt_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) begin
            checks++; failures++;
            $display("FAIL wt_ready_timeout got=%b want=1", wt_ready);
        end
        @(posedge clk); #1;
        wt_valid = 1'b0; wt_last = 1'b0;
    endtask

    task automatic send_in(input logic [WIDTH-1:0] d, input logic last, input logic [1:0] s);
        int n = 0;
        in_data = d; in_last = last; sel = s; in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) begin
            checks++; failures++;
            $display("FAIL in_ready_timeout got=%b want=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) begin
            checks++; failures++;
            $display("FAIL out_valid_timeout got=%b want=1", out_valid);
        end
    endtask

    task automatic handshake(input logic r);
        out_ready = 1'b1; reuse = r;
        @(posedge clk); #1;
        out_ready = 1'b0; reuse = 1'b0;
    endtask

    task automatic test_reset();
        logic [70:0] got, exp;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        got = {out_valid, out_data, fwd_valid, fwd_data, count, ovf, in_ready, wt_ready, state};
        exp = {1'b0, 32'd0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 2'd0};
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL reset_outputs got=%h want=%h", got, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [70:0] got, exp;
        sgn = 1'b0;
        send_wt(16'd41, 1'b1);
        send_in(16'd3, 1'b0, 2'd0);
        checks++;
        if (state !== 2'd2 || count !== 16'd1) begin
            failures++; $display("FAIL mid_setup got state=%0d count=%0d want 2/1", state, count);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        got = {out_valid, out_data, fwd_valid, fwd_data, count, ovf, in_ready, wt_ready, state};
        exp = {1'b0, 32'd0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 2'd0};
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL mid_reset_outputs got=%h want=%h", got, exp);
        end
        send_wt(16'd2, 1'b1);
        send_in(16'd7, 1'b1, 2'd0);
        wait_out();
        checks++;
        if (out_data !== 32'd14) begin
            failures++; $display("FAIL reload_after_reset got=%0d want=14", out_data);
        end
        handshake(1'b0);
    endtask

    task automatic test_unsigned();
        sgn = 1'b0;
        send_wt(16'd3, 1'b0);
        checks++;
        if (state !== 2'd1 || in_ready !== 1'b0 || wt_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_state got st=%0d in_rdy=%b wt_rdy=%b want 1/0/1",
                     state, in_ready, wt_ready);
        end
        send_wt(16'd5, 1'b0);
        send_wt(16'd7, 1'b0);
        send_wt(16'd9, 1'b1);
        checks++;
        if (state !== 2'd2 || in_ready !== 1'b1 || wt_ready !== 1'b0) begin
            failures++;
            $display("FAIL compute_state got st=%0d in_rdy=%b wt_rdy=%b want 2/1/0",
                     state, in_ready, wt_ready);
        end
        send_in(16'd2, 1'b0, 2'd1);
        checks++;
        if ({fwd_valid, fwd_data} !== {1'b1, 16'd2}) begin
            failures++; $display("FAIL fwd_2 got v=%b d=%0d want 1/2", fwd_valid, fwd_data);
        end
        @(posedge clk); #1;
        checks++;
        if (fwd_valid !== 1'b0) begin
            failures++; $display("FAIL fwd_idle got=%b want=0", fwd_valid);
        end
        send_in(16'd4, 1'b0, 2'd1);
        checks++;
        if ({fwd_valid, fwd_data} !== {1'b1, 16'd4}) begin
            failures++; $display("FAIL fwd_4 got v=%b d=%0d want 1/4", fwd_valid, fwd_data);
        end
        send_in(16'd6, 1'b1, 2'd1);
        checks++;
        if ({fwd_valid, fwd_data} !== {1'b1, 16'd6}) begin
            failures++; $display("FAIL fwd_6 got v=%b d=%0d want 1/6", fwd_valid, fwd_data);
        end
        wait_out();
        checks++;
        if (out_data !== 32'd60 || count !== 16'd3) begin
            failures++; $display("FAIL unsigned_result got=%0d cnt=%0d want 60/3", out_data, count);
        end
        handshake(1'b0);
        checks++;
        if (state !== 2'd0 || count !== 16'd0) begin
            failures++; $display("FAIL back_to_idle got st=%0d cnt=%0d want 0/0", state, count);
        end
    endtask

    task automatic test_signed();
        sgn = 1'b1;
        send_wt(16'hFFFE, 1'b0);
        sgn = 1'b0;  // mode must stay latched from the first weight
        send_wt(16'd1, 1'b1);
        send_in(16'd3, 1'b0, 2'd0);
        send_in(16'hFFFC, 1'b1, 2'd0);
        wait_out();
        checks++;
        if (out_data !== 32'd2) begin
            failures++; $display("FAIL signed_pass1 got=%h want=00000002", out_data);
        end
        handshake(1'b1);
        send_in(16'd5, 1'b1, 2'd0);
        wait_out();
        checks++;
        if (out_data !== 32'hFFFFFFF6) begin
            failures++; $display("FAIL signed_pass2 got=%h want=fffffff6", out_data);
        end
        handshake(1'b0);
    endtask

    task automatic test_hold_reuse();
        sgn = 1'b0;
        send_wt(16'd3, 1'b0);
        send_wt(16'd5, 1'b1);
        send_in(16'd4, 1'b1, 2'd0);
        wait_out();
        in_valid = 1'b1; in_data = 16'd100; in_last = 1'b1; sel = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_data !== 32'd12 || in_ready !== 1'b0 || out_valid !== 1'b1
                || count !== 16'd1) begin
                failures++;
                $display("FAIL hold_cycle%0d got d=%0d in_rdy=%b ov=%b cnt=%0d want 12/0/1/1",
                         i, out_data, in_ready, out_valid, count);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        handshake(1'b1);
        checks++;
        if (state !== 2'd2 || count !== 16'd0) begin
            failures++; $display("FAIL reuse_state got st=%0d cnt=%0d want 2/0", state, count);
        end
        send_in(16'd1, 1'b1, 2'd1);
        wait_out();
        checks++;
        if (out_data !== 32'd5) begin
            failures++; $display("FAIL reuse_result got=%0d want=5", out_data);
        end
        handshake(1'b0);
    endtask

    task automatic test_overflow();
        logic [ACC-1:0] exp_d;
        logic           exp_o;
`ifdef PE_SAT_EN
        exp_d = 32'hFFFFFFFF; exp_o = 1'b1;
`else
        exp_d = 32'hFFFA0003; exp_o = 1'b0;
`endif
        sgn = 1'b0;
        send_wt(16'hFFFF, 1'b1);
        send_in(16'hFFFF, 1'b0, 2'd0);
        send_in(16'hFFFF, 1'b0, 2'd0);
        send_in(16'hFFFF, 1'b1, 2'd0);
        wait_out();
        checks++;
        if (out_data !== exp_d || ovf !== exp_o) begin
            failures++;
            $display("FAIL overflow got d=%h ovf=%b want %h/%b", out_data, ovf, exp_d, exp_o);
        end
        handshake(1'b0);
        checks++;
        if (ovf !== 1'b0 || count !== 16'd0) begin
            failures++; $display("FAIL ovf_clear got ovf=%b cnt=%0d want 0/0", ovf, count);
        end
    endtask

    task automatic test_wrap();
        sgn = 1'b0;
        for (int i = 1; i <= 6; i++) send_wt(16'(i), (i == 6));
        send_in(16'd2, 1'b1, 2'd0);
        wait_out();
        checks++;
        if (out_data !== 32'd10) begin
            failures++; $display("FAIL wrap_sel0 got=%0d want=10", out_data);
        end
        handshake(1'b1);
        send_in(16'd2, 1'b1, 2'd1);
        wait_out();
        checks++;
        if (out_data !== 32'd12) begin
            failures++; $display("FAIL wrap_sel1 got=%0d want=12", out_data);
        end
        handshake(1'b1);
        send_in(16'd2, 1'b1, 2'd2);
        wait_out();
        checks++;
        if (out_data !== 32'd6) begin
            failures++; $display("FAIL wrap_sel2 got=%0d want=6", out_data);
        end
        handshake(1'b0);
        checks++;
        if (state !== 2'd0) begin
            failures++; $display("FAIL wrap_idle got=%0d want=0", state);
        end
    endtask

    initial begin
        rst = 1'b0; sgn = 1'b0;
        wt_valid = 1'b0; wt_data = '0; wt_last = 1'b0;
        sel = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b0; reuse = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_reset_mid();
        test_unsigned();
        test_signed();
        test_hold_reuse();
        test_overflow();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ws_pe_mac_v2.md
Name: ws_pe_mac_v2

Overview:
Second-generation weight-stationary processing element for the systolic array.
- Holds a bank of NUM_W stationary weights, loaded over a valid/ready stream; w_sel picks the active weight at compute time.
- Consumes a valid/ready input stream and accumulates weight*input, signed or unsigned, into a wide accumulator.
- Forwards each accepted input to the neighbouring PE one cycle later, then drains the result over a valid/ready output handshake.

Parameters:
WIDTH, 16, operand width of weights and inputs
ACC_WIDTH, 40, accumulator width; must be >= 2*WIDTH
NUM_W, 4, weight bank depth; must be >= 2
CNT_WIDTH, 16, width of the accepted-input counter

Ports:
w_clk  in  1  clock; all logic on the rising edge
w_rst  in  1  reset, synchronous and active-high
w_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled on the first weight accepted from IDLE
w_wt_valid  in  1  weight stream valid
w_wt_ready  out  1  weight stream ready
w_wt_data  in  WIDTH  weight value
w_wt_last  in  1  marks the final weight of a load
w_sel  in  $clog2(NUM_W)  weight bank index used during compute
w_in_valid  in  1  input stream valid
w_in_ready  out  1  input stream ready
w_in_data  in  WIDTH  input operand
w_in_last  in  1  marks the final input of a pass
w_fwd_valid  out  1  forwarded input valid (systolic output)
w_fwd_data  out  WIDTH  forwarded input value
w_out_valid  out  1  result valid
w_out_ready  in  1  result ready
w_out_data  out  ACC_WIDTH  accumulated result
w_reuse  in  1  sampled at result handshake: 1 = keep weights and return to COMPUTE
w_count  out  CNT_WIDTH  inputs accepted in the current pass
w_ovf  out  1  sticky overflow flag
w_state  out  2  FSM state encoding

Behaviour:
- Reset: on any rising edge with w_rst=1, state=IDLE, bank entries=0, accumulator=0, write pointer=0, count=0. Reset overrides all other activity, including mid-operation.
- Output values after reset: w_out_valid=0, w_out_data=0, w_fwd_valid=0, w_fwd_data=0, w_count=0, w_ovf=0, w_in_ready=0, w_wt_ready=1, w_state=0.
- FSM encodings: IDLE=0, LOAD=1, COMPUTE=2, DRAIN=3.
- w_wt_ready=1 only in IDLE and LOAD. w_in_ready=1 only in COMPUTE. w_out_valid=1 only in DRAIN. All three are decoded from the state register; none is combinational on inputs.
- Weight transfer (valid&ready):
  - Writes bank[wptr]; wptr increments and wraps from NUM_W-1 to 0, so later writes overwrite.
  - IDLE to LOAD on a transfer without last. IDLE or LOAD to COMPUTE on a transfer with last.
  - wptr returns to 0 on entering COMPUTE.
- Input transfer in COMPUTE:
  - Product = bank[w_sel] * w_in_data, full 2*WIDTH bits, computed signed or unsigned per the latched mode.
  - Product is sign- or zero-extended to ACC_WIDTH and added to the accumulator; result visible the next cycle.
  - w_count increments and saturates at all-ones.
  - w_sel >= NUM_W uses a weight of 0.
  - A transfer with last is accumulated, then the FSM moves to DRAIN.
- Forwarding: w_fwd_valid/w_fwd_data are registered copies of each accepted input, latency 1 cycle. w_fwd_valid=0 in cycles with no transfer.
- DRAIN:
  - w_out_data shows the accumulator and stays stable while w_out_ready=0.
  - On handshake: accumulator, count and ovf clear. Next state is COMPUTE with weights kept if w_reuse=1, else IDLE.
- Streams are ignored in any state where their ready is 0. Weight and input valid in the same cycle is not a conflict, because only one ready can be high.

Optional Feature:
PE_SAT_EN
- Defined: the sum is computed at ACC_WIDTH+1 bits. On overflow the accumulator clamps to the max/min of the latched mode and w_ovf sets, sticky until the DRAIN handshake.
- Undefined: the accumulator wraps modulo 2^ACC_WIDTH and w_ovf is tied to 0.

Test Plan:
1. Assert w_rst for 2 cycles mid-COMPUTE with an accumulator of 123 -> all outputs at reset values, w_state=0, w_wt_ready=1. A new load then works.
2. Unsigned; weights 3,5,7,9 (last on 9); w_sel=1; inputs 2,4,6 (last on 6) -> w_out_data=60, w_count=3. w_fwd_data shows 2,4,6 one cycle after each input handshake.
3. Signed; weights 16'hFFFE and 1 (last); w_sel=0; inputs 3, 16'hFFFC (last) -> w_out_data=2. Second pass with single input 5 -> w_out_data=-10 sign-extended.
4. Result held with w_out_ready=0 for 5 cycles -> w_out_data stable, w_in_ready=0. Then handshake with w_reuse=1 -> COMPUTE, accumulator 0. Input 1 with w_sel=1 (weights 3,5) -> result 5.
5. ACC_WIDTH=32, WIDTH=16, unsigned; weight 16'hFFFF; three inputs 16'hFFFF -> with PE_SAT_EN w_out_data=32'hFFFFFFFF and w_ovf=1; without it w_out_data=32'hFFFA0003 and w_ovf=0.
6. Load 6 weights into NUM_W=4 (values 1..6, last on 6) -> bank={5,6,3,4}; w_sel=0 with input 2 -> 10.
